// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: address/instruction widths, reset PC and bubble word.
package mips_pkg;
  localparam int                PCL      = 32;
  localparam int                INST_W   = 32;
  localparam logic [PCL-1:0]    RESET_PC = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;
endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush beats stall beats load; valid marks a real instruction.
module ifid_reg
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic [INST_W-1:0] inst_d,
  input  logic [PCL-1:0]    pc4_d,
  output logic [INST_W-1:0] ifid_inst,
  output logic [PCL-1:0]    ifid_pc4,
  output logic              ifid_valid
);

  // Flush squashes to a bubble but keeps pc4; stall holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_inst  <= NOP_INST;
      ifid_pc4   <= {PCL{1'b0}};
      ifid_valid <= 1'b0;
    end else if (flush) begin
      ifid_inst  <= NOP_INST;
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      ifid_inst  <= inst_d;
      ifid_pc4   <= pc4_d;
      ifid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, next-PC selection, misaligned-target flag and delivered-instruction count.
module fetch_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect,
  input  logic [PCL-1:0]    redirect_pc,
  output logic [PCL-1:0]    imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] ifid_inst,
  output logic [PCL-1:0]    ifid_pc4,
  output logic              ifid_valid,
  output logic              misalign_err,
  output logic [31:0]       fetch_count
);

  localparam logic [PCL-1:0] PC_STEP = PCL'(3'd4);

  logic [PCL-1:0] pc_r;
  logic [PCL-1:0] pc4_s;
  logic [PCL-1:0] next_pc_s;
  logic           load_s;

  assign imem_addr = pc_r;
  assign pc4_s     = pc_r + PC_STEP;
  assign load_s    = !flush && !stall;

  // Next-PC select: redirect wins over stall, otherwise fall through sequentially.
  always_comb begin
    next_pc_s = pc4_s;
    if (redirect) begin
      next_pc_s = {redirect_pc[PCL-1:2], 2'b00};
    end else if (stall) begin
      next_pc_s = pc_r;
    end else begin
      next_pc_s = pc4_s;
    end
  end

  // Program counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= next_pc_s;
    end
  end

  // Sticky flag: any redirect target with low address bits set, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
    end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      misalign_err <= 1'b1;
    end
  end

  // Counts every edge on which IF/ID accepts a new instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= 32'd0;
    end else if (load_s) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  ifid_reg u_ifid (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .flush      (flush),
    .inst_d     (imem_data),
    .pc4_d      (pc4_s),
    .ifid_inst  (ifid_inst),
    .ifid_pc4   (ifid_pc4),
    .ifid_valid (ifid_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: cycle model compared every negedge plus hand-computed checkpoints.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_data;
  logic [31:0] ifid_inst, ifid_pc4;
  logic        ifid_valid, misalign_err;
  logic [31:0] fetch_count;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state
  logic [31:0] m_pc    = 32'h0;
  logic [31:0] m_inst  = 32'h0;
  logic [31:0] m_pc4   = 32'h0;
  logic        m_valid = 1'b0;
  logic        m_err   = 1'b0;
  logic [31:0] m_cnt   = 32'h0;

  always #5 clk = ~clk;

  // Instruction memory: word N (byte address 4N) holds 0x2000_0000 + N
  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h2000_0000 + (a >> 2);
  endfunction

  assign imem_data = mem(imem_addr);

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .ifid_inst    (ifid_inst),
    .ifid_pc4     (ifid_pc4),
    .ifid_valid   (ifid_valid),
    .misalign_err (misalign_err),
    .fetch_count  (fetch_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: what the stage must hold after each edge, from the fetch rules
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 32'h0; m_inst <= 32'h0; m_pc4 <= 32'h0;
      m_valid <= 1'b0; m_err <= 1'b0; m_cnt <= 32'h0;
    end else begin
      if (flush) begin
        m_inst <= 32'h0; m_valid <= 1'b0;
      end else if (!stall) begin
        m_inst <= mem(m_pc); m_pc4 <= m_pc + 32'd4; m_valid <= 1'b1; m_cnt <= m_cnt + 32'd1;
      end
      if (redirect) begin
        m_pc <= redirect_pc & 32'hFFFF_FFFC;
        if (redirect_pc % 32'd4 != 32'd0) m_err <= 1'b1;
      end else if (!stall) begin
        m_pc <= m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("imem_addr",    imem_addr,    m_pc);
      chk("ifid_inst",    ifid_inst,    m_inst);
      chk("ifid_pc4",     ifid_pc4,     m_pc4);
      chk("ifid_valid",   {31'd0, ifid_valid},   {31'd0, m_valid});
      chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
      chk("fetch_count",  fetch_count,  m_cnt);
    end
  end

  task automatic step(input logic st, input logic fl, input logic rd, input logic [31:0] rpc);
    stall = st; flush = fl; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #1;
    cmp_en = 1'b1;
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    #7 rst_n = 1'b1;
    chk("first_valid", {31'd0, ifid_valid}, 32'd0);

    // Free-running fetch
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("run1_addr", imem_addr, 32'h4);
    chk("run1_inst", ifid_inst, 32'h2000_0000);
    chk("run1_pc4",  ifid_pc4,  32'h4);
    chk("run1_valid", {31'd0, ifid_valid}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("run2_addr", imem_addr, 32'h8);
    chk("run2_inst", ifid_inst, 32'h2000_0001);

    // Stall two cycles at PC=8
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall_addr",  imem_addr,   32'h8);
    chk("stall_inst",  ifid_inst,   32'h2000_0001);
    chk("stall_count", fetch_count, 32'd2);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("resume_addr",  imem_addr,   32'hC);
    chk("resume_inst",  ifid_inst,   32'h2000_0002);
    chk("resume_pc4",   ifid_pc4,    32'hC);
    chk("resume_count", fetch_count, 32'd3);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("pc10", imem_addr, 32'h10);

    // Redirect+flush from 0x10 to 0x40
    step(1'b0, 1'b1, 1'b1, 32'h40);
    chk("rdf_addr",  imem_addr, 32'h40);
    chk("rdf_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rdf_pc4",   ifid_pc4,  32'h10);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("tgt_pc4",   ifid_pc4,  32'h44);
    chk("tgt_inst",  ifid_inst, 32'h2000_0010);
    chk("tgt_valid", {31'd0, ifid_valid}, 32'd1);

    // Misaligned target, then an aligned one: flag stays set
    step(1'b0, 1'b0, 1'b1, 32'h42);
    chk("mis_addr", imem_addr, 32'h40);
    chk("mis_err",  {31'd0, misalign_err}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 32'h80);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("mis_sticky", {31'd0, misalign_err}, 32'd1);

    // Wrap at top of address space
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_tgt", imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc4",  ifid_pc4,  32'h0);

    // stall+redirect, then stall+flush
    step(1'b1, 1'b0, 1'b1, 32'h100);
    chk("strd_addr", imem_addr, 32'h100);
    chk("strd_pc4",  ifid_pc4,  32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("stfl_addr",  imem_addr, 32'h100);
    chk("stfl_valid", {31'd0, ifid_valid}, 32'd0);

    // Asynchronous reset pulse between edges during a stall
    step(1'b1, 1'b0, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_addr",  imem_addr, 32'h0);
    chk("arst_inst",  ifid_inst, 32'h0);
    chk("arst_pc4",   ifid_pc4,  32'h0);
    chk("arst_valid", {31'd0, ifid_valid},   32'd0);
    chk("arst_err",   {31'd0, misalign_err}, 32'd0);
    chk("arst_count", fetch_count, 32'd0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("post_addr",  imem_addr,   32'h4);
    chk("post_inst",  ifid_inst,   32'h2000_0000);
    chk("post_count", fetch_count, 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'h0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS pipeline: owns the program counter, drives the byte address into the instruction memory, and registers the returned 32-bit instruction into the IF/ID pipeline register. It sits between the hazard/branch logic (stall, flush, redirect) and the decode stage. The instruction memory read is combinational, so a fetch completes in the same cycle its address is driven.

## Interface
- PCL, 32, PC and address width in bits
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INST, 32'h0000_0000, instruction word loaded into IF/ID on flush or reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold PC and IF/ID contents (load-use hazard)
- flush  in  1  squash IF/ID contents to a bubble at the next edge
- redirect  in  1  taken branch/jump; load redirect_pc into PC
- redirect_pc  in  PCL  branch/jump target byte address
- imem_addr  out  PCL  byte address to instruction memory (equals PC)
- imem_data  in  32  instruction word returned combinationally
- ifid_inst  out  32  registered instruction for decode
- ifid_pc4  out  PCL  registered PC+4 of that instruction
- ifid_valid  out  1  ifid_inst is a real instruction (0 = bubble)
- misalign_err  out  1  sticky: a redirect target had nonzero bits [1:0]
- fetch_count  out  32  number of instructions delivered to IF/ID

## Operation
- Reset (rst_n low, asynchronous): PC=RESET_PC, ifid_inst=NOP_INST, ifid_pc4=0, ifid_valid=0, misalign_err=0, fetch_count=0.
- imem_addr = PC at all times, combinational.
- Next-PC priority: redirect > stall > sequential (PC+4, modulo 2^PCL; 0xFFFF_FFFC wraps to 0).
- Redirect target loaded as {redirect_pc[PCL-1:2], 2'b00}; if redirect_pc[1:0] != 0, misalign_err sets and stays set until reset.
- IF/ID priority: flush > stall > load.
  - flush: ifid_inst=NOP_INST, ifid_valid=0, ifid_pc4 unchanged.
  - stall (no flush): all IF/ID fields hold.
  - load: ifid_inst=imem_data, ifid_pc4=PC+4, ifid_valid=1.
- redirect alone does not squash IF/ID; hazard logic asserts flush together with redirect when the fetched-in-flight instruction must die.
- fetch_count increments by 1 on every edge where IF/ID performs a load; wraps at 2^32.

## Timing
- Zero-cycle address-to-data: imem_data sampled at the same edge that updates PC.
- Instruction at PC appears on ifid_inst one edge after PC is presented.
- Redirect at edge N: PC = target after edge N; target instruction on ifid_inst after edge N+1.
- Stall held K cycles: PC and IF/ID frozen for K edges; fetch_count unchanged.
- stall+flush same cycle: PC holds, IF/ID becomes bubble.
- stall+redirect same cycle: PC takes target, IF/ID holds (unless flush).
- rst_n deasserted mid-operation: all state returns to reset values immediately, regardless of clk; first load occurs on the first edge with rst_n high.

## Structure
- Shared package mips_pkg: PCL, RESET_PC, NOP_INST, INST_W=32.
- One sub-module: ifid_reg (IF/ID register with flush/stall priority and valid bit); PC, next-PC mux, error flag and counter live in fetch_stage.

## Test plan
- Reset then 4 free-running cycles with memory returning 0x2000_000N at address 4N -> imem_addr 0,4,8,12; ifid_inst 0x2000_0000..0x2000_0002 with ifid_pc4 4,8,12; ifid_valid 0 in first cycle then 1; fetch_count 3.
- stall high 2 cycles at PC=8 -> imem_addr stays 8, IF/ID holds, fetch_count unchanged; resumes at 12 after release.
- redirect+flush with redirect_pc=0x40 at PC=0x10 -> next imem_addr 0x40, ifid_valid 0 for one cycle, then ifid_pc4=0x44.
- redirect_pc=0x42 -> PC=0x40, misalign_err=1 and remains 1 through subsequent redirects until rst_n low.
- Redirect to 0xFFFF_FFFC, no stall -> next PC 0x0000_0000, ifid_pc4=0x0000_0000.
- rst_n pulsed low between clock edges during a stall -> outputs to reset values immediately; ifid_inst=NOP_INST, ifid_valid=0.
